// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder with valid/ready handshakes on both sides.
// One sum bit per clock, LSB first; result held in DONE until taken.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic ha_s, ha_c, sum, carry;

    // Two half adders plus an OR form the full-adder slice.
    assign ha_s  = a_q[0] ^ b_q[0];
    assign ha_c  = a_q[0] & b_q[0];
    assign sum   = ha_s ^ c_q;
    assign carry = ha_c | (c_q & ha_s);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = CIN;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                s_d   = WIDTH'({sum, s_q} >> 1);
                c_d   = carry;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign S         = s_q;
    assign C         = c_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl at WIDTH 8, 2 and 1.
// Expected sums are hand-computed constants or simple integer adds.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       iv8 = 0, ir8, ci8 = 0, ov8, or8 = 0, c8, bz8;
    logic [7:0] a8 = 0, b8 = 0, s8;
    logic       iv2 = 0, ir2, ci2 = 0, ov2, or2 = 0, c2, bz2;
    logic [1:0] a2 = 0, b2 = 0, s2;
    logic       iv1 = 0, ir1, ci1 = 0, ov1, or1 = 0, c1, bz1;
    logic [0:0] a1 = 0, b1 = 0, s1;

    serial_adder_ctrl #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8),
        .A(a8), .B(b8), .CIN(ci8), .out_valid(ov8), .out_ready(or8),
        .S(s8), .C(c8), .busy(bz8)
    );
    serial_adder_ctrl #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .A(a2), .B(b2), .CIN(ci2), .out_valid(ov2), .out_ready(or2),
        .S(s2), .C(c2), .busy(bz2)
    );
    serial_adder_ctrl #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .A(a1), .B(b1), .CIN(ci1), .out_valid(ov1), .out_ready(or1),
        .S(s1), .C(c1), .busy(bz1)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b,
                          input logic ci);
        int n = 0;
        while (!ir8 && n < 20) begin @(posedge clk); #1; n++; end
        check("w8_ready", {31'd0, ir8}, 1);
        a8 = a; b8 = b; ci8 = ci; iv8 = 1;
        @(posedge clk); #1;
        iv8 = 0;
        check("w8_busy", {31'd0, bz8}, 1);
    endtask

    task automatic wait8(input string tag);
        int n = 0;
        while (!ov8 && n < 20) begin @(posedge clk); #1; n++; end
        check({tag, "_lat"}, n, 8);
    endtask

    task automatic take8(input string tag);
        or8 = 1;
        @(posedge clk); #1;
        or8 = 0;
        check({tag, "_ov0"}, {31'd0, ov8}, 0);
        check({tag, "_ir1"}, {31'd0, ir8}, 1);
    endtask

    task automatic op8(input string tag, input logic [7:0] a,
                       input logic [7:0] b, input logic ci,
                       input logic [7:0] es, input logic ec);
        start8(a, b, ci);
        wait8(tag);
        check({tag, "_S"}, {24'd0, s8}, {24'd0, es});
        check({tag, "_C"}, {31'd0, c8}, {31'd0, ec});
        take8(tag);
    endtask

    initial begin
        int n, hs, last, e;
        #1 rst = 1;
        #1;
        check("rst_ir", {31'd0, ir8}, 1);
        check("rst_ov", {31'd0, ov8}, 0);
        check("rst_busy", {31'd0, bz8}, 0);
        check("rst_S", {24'd0, s8}, 0);
        check("rst_C", {31'd0, c8}, 0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        op8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        op8("ovf", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op8("a5", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

        // Backpressure: result must hold while inputs toggle.
        start8(8'h5C, 8'h33, 1'b0);
        wait8("bp");
        for (int i = 0; i < 5; i++) begin
            iv8 = i[0]; a8 = 8'(i * 37); b8 = ~a8; ci8 = ~i[0];
            check("bp_S", {24'd0, s8}, 32'h8F);
            check("bp_C", {31'd0, c8}, 0);
            check("bp_ir", {31'd0, ir8}, 0);
            @(posedge clk); #1;
        end
        iv8 = 0;
        check("bp_ov", {31'd0, ov8}, 1);
        check("bp_S_last", {24'd0, s8}, 32'h8F);
        take8("bp");
        n = 0;
        repeat (10) begin @(posedge clk); #1; n += int'(ov8); end
        check("bp_once", n, 0);

        // Asynchronous reset in the third RUN cycle.
        start8(8'h3C, 8'h0F, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1;
        #1;
        check("rr_ov", {31'd0, ov8}, 0);
        check("rr_ir", {31'd0, ir8}, 1);
        check("rr_busy", {31'd0, bz8}, 0);
        check("rr_S", {24'd0, s8}, 0);
        @(posedge clk); #1 rst = 0;
        n = 0;
        repeat (12) begin @(posedge clk); #1; n += int'(ov8); end
        check("rr_noresult", n, 0);
        op8("post", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // WIDTH=2 exhaustive with random output stalls.
        last = 0;
        for (int i = 0; i < 32; i++) begin
            n = 0;
            while (!ir2 && n < 20) begin @(posedge clk); #1; n++; end
            check("w2_ready", {31'd0, ir2}, 1);
            a2 = 2'(i); b2 = 2'(i >> 2); ci2 = i[4]; iv2 = 1;
            @(posedge clk); #1;
            hs = cyc;
            iv2 = 0;
            if (i > 0) check("w2_ii", {31'd0, (hs - last) >= 4}, 1);
            last = hs;
            n = 0;
            while (!ov2 && n < 20) begin @(posedge clk); #1; n++; end
            check("w2_lat", n, 2);
            e = (i & 3) + ((i >> 2) & 3) + ((i >> 4) & 1);
            check("w2_sum", {29'd0, c2, s2}, e);
            n = 0;
            do begin
                or2 = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                n++;
            end while (ov2 && n < 60);
            or2 = 0;
            check("w2_drain", {31'd0, ov2}, 0);
        end

        // WIDTH=1 boundary.
        a1 = 1; b1 = 1; ci1 = 1; iv1 = 1;
        @(posedge clk); #1;
        iv1 = 0;
        n = 0;
        while (!ov1 && n < 20) begin @(posedge clk); #1; n++; end
        check("w1_lat", n, 1);
        check("w1_S", {31'd0, s1}, 1);
        check("w1_C", {31'd0, c1}, 1);
        or1 = 1;
        @(posedge clk); #1;
        or1 = 0;
        check("w1_ir", {31'd0, ir1}, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
